// File: rtl/uart_rx_frame_assembler.sv
// Frame assembler: buffers UART bytes until the idle-line pulse, then drains them as a stream.
// Optional trailing additive checksum enabled by `define UART_FRAME_CHECKSUM_EN.
module uart_rx_frame_assembler #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data_i,
  input  logic             in_valid_i,
  input  logic             in_frame_end_i,
  output logic [7:0]       out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             out_last_o,
  output logic [LEN_W-1:0] frame_len_o,
  output logic             frame_len_vld_o,
  output logic             frame_ovf_o,
  output logic [15:0]      drop_cnt_o,
  output logic             crc_err_o
);

  typedef enum logic {S_COLLECT, S_DRAIN} state_e;

  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
  localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);

  logic [7:0] mem [DEPTH];

  state_e           state_q, state_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [LEN_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [LEN_W-1:0] frame_len_q, frame_len_d;
  logic             len_vld_q, len_vld_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [7:0]       rd_data_q;
  logic [15:0]      drop_q, drop_d;
  logic             wr_en, rd_en, drop_en, fire, frame_close;
  logic [LEN_W-1:0] count_inc;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rd_cnt_d    = rd_cnt_q;
    frame_len_d = frame_len_q;
    len_vld_d   = 1'b0;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    drop_en     = 1'b0;
    frame_close = 1'b0;
    count_inc   = count_q;
    fire        = out_valid_q & out_ready_i;

    unique case (state_q)
      S_COLLECT: begin
        if (in_valid_i) begin
          if (count_q != DEPTH_L) begin
            wr_en     = 1'b1;
            count_inc = count_q + ONE_L;
            if (count_q == '0) ovf_d = 1'b0;
          end else begin
            drop_en = 1'b1;
            ovf_d   = 1'b1;
          end
        end
        count_d = count_inc;
        // count_inc already includes a byte arriving alongside the idle pulse
        if (in_frame_end_i && count_inc != '0) begin
          frame_close = 1'b1;
          len_vld_d   = 1'b1;
          rd_cnt_d    = '0;
`ifdef UART_FRAME_CHECKSUM_EN
          if (count_inc == ONE_L) begin
            frame_len_d = '0;
            count_d     = '0;
          end else begin
            frame_len_d = count_inc - ONE_L;
            state_d     = S_DRAIN;
          end
`else
          frame_len_d = count_inc;
          state_d     = S_DRAIN;
`endif
        end
      end
      S_DRAIN: begin
        drop_en = in_valid_i;
        // the read register doubles as the output stage, so it only reloads when free
        if (rd_cnt_q != frame_len_q && (!out_valid_q || out_ready_i)) begin
          rd_en       = 1'b1;
          rd_cnt_d    = rd_cnt_q + ONE_L;
          out_valid_d = 1'b1;
          out_last_d  = (rd_cnt_q == frame_len_q - ONE_L);
        end else if (fire) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
        if (fire && out_last_q) begin
          state_d  = S_COLLECT;
          count_d  = '0;
          rd_cnt_d = '0;
        end
      end
      default: state_d = S_COLLECT;
    endcase

    drop_d = (drop_en && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_COLLECT;
      count_q     <= '0;
      rd_cnt_q    <= '0;
      frame_len_q <= '0;
      len_vld_q   <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rd_cnt_q    <= rd_cnt_d;
      frame_len_q <= frame_len_d;
      len_vld_q   <= len_vld_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      drop_q      <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[count_q[ADDR_W-1:0]] <= in_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else if (rd_en) rd_data_q <= mem[rd_cnt_q[ADDR_W-1:0]];
  end

`ifdef UART_FRAME_CHECKSUM_EN
  // sum_q is the total of every stored byte; chk_q is the most recent one
  logic [7:0] sum_q, sum_d, chk_q, chk_d, sum_eff, chk_eff;
  logic       crc_q, crc_d;

  always_comb begin
    sum_eff = sum_q;
    chk_eff = chk_q;
    if (wr_en) begin
      sum_eff = (count_q == '0) ? in_data_i : sum_q + in_data_i;
      chk_eff = in_data_i;
    end
    sum_d = sum_eff;
    chk_d = chk_eff;
    crc_d = 1'b0;
    if (frame_close)
      crc_d = ovf_d || (count_inc == ONE_L) || ((sum_eff - chk_eff) != chk_eff);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      chk_q <= '0;
      crc_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      chk_q <= chk_d;
      crc_q <= crc_d;
    end
  end

  assign crc_err_o = crc_q;
`else
  assign crc_err_o = 1'b0;
`endif

  assign out_data_o      = rd_data_q;
  assign out_valid_o     = out_valid_q;
  assign out_last_o      = out_last_q;
  assign frame_len_o     = frame_len_q;
  assign frame_len_vld_o = len_vld_q;
  assign frame_ovf_o     = ovf_q;
  assign drop_cnt_o      = drop_q;

endmodule
